// File: rtl/flash_bus_sequencer.sv
// NOR-flash pin sequencer: timed cs_n/oe_n/we_n strobes for single-word requests.
// Optional busy polling after writes: define FLASH_RDY_POLL_EN.
module flash_bus_sequencer #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int RD_WAIT    = 4,
  parameter int WR_SETUP   = 1,
  parameter int WR_PULSE   = 3,
  parameter int WR_HOLD    = 1,
  parameter int TURNAROUND = 1,
  parameter int TMO_W      = 16
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_dq_o,
  output logic              flash_dq_oe,
  input  logic [DATA_W-1:0] flash_dq_i,
  output logic              flash_cs_n,
  output logic              flash_oe_n,
  output logic              flash_we_n,
  input  logic              flash_ry_by
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_ACC = 3'd1;
  localparam logic [2:0] S_WR_SET = 3'd2;
  localparam logic [2:0] S_WR_PUL = 3'd3;
  localparam logic [2:0] S_WR_HLD = 3'd4;
  localparam logic [2:0] S_RSP    = 3'd5;
  localparam logic [2:0] S_TURN   = 3'd6;
`ifdef FLASH_RDY_POLL_EN
  localparam logic [2:0] S_WR_POLL = 3'd7;
`endif

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // The poll start delay (2) shares the wait-state counter.
  localparam int MAXP  = imax(imax(imax(RD_WAIT, WR_SETUP),
                                   imax(WR_PULSE, WR_HOLD)),
                              imax(TURNAROUND, 2));
  localparam int CNT_W = $clog2(MAXP + 1);

  localparam logic [CNT_W-1:0] LD_RD  = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] LD_SET = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PUL = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HLD = CNT_W'(WR_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_TA  =
    CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cnt_zero;
  logic              cs_n_q, cs_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_o_q, dq_o_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef FLASH_RDY_POLL_EN
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] LD_POLL  = CNT_W'(2);

  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       ry_sync_q, ry_sync_d;
`endif

  assign cnt_zero  = (cnt_q == '0);
  assign req_ready = (state_q == S_IDLE) && !rsp_valid_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    dq_o_d      = dq_o_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
`ifdef FLASH_RDY_POLL_EN
    err_d       = err_q;
    tmo_d       = tmo_q;
    ry_sync_d   = {ry_sync_q[0], flash_ry_by};
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d = req_addr;
          if (req_we) begin
            dq_o_d  = req_wdata;
            state_d = S_WR_SET;
            cnt_d   = LD_SET;
          end else begin
            state_d = S_RD_ACC;
            cnt_d   = LD_RD;
          end
        end
      end
      S_RD_ACC: begin
        if (cnt_zero) begin
          rdata_d     = flash_dq_i;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_SET: begin
        if (cnt_zero) begin
          state_d = S_WR_PUL;
          cnt_d   = LD_PUL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_PUL: begin
        if (cnt_zero) begin
          state_d = S_WR_HLD;
          cnt_d   = LD_HLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_HLD: begin
        if (cnt_zero) begin
`ifdef FLASH_RDY_POLL_EN
          state_d = S_WR_POLL;
          cnt_d   = LD_POLL;
          tmo_d   = '0;
`else
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          state_d     = S_RSP;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef FLASH_RDY_POLL_EN
      S_WR_POLL: begin
        // Give the flash time to pull ry_by low before trusting it.
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (ry_sync_q[1]) begin
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          err_d       = 1'b0;
          state_d     = S_RSP;
        end else if (tmo_q == TMO_LAST) begin
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          err_d       = 1'b1;
          state_d     = S_RSP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`endif
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef FLASH_RDY_POLL_EN
          err_d       = 1'b0;
`endif
          if (TURNAROUND == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_TURN;
            cnt_d   = LD_TA;
          end
        end
      end
      S_TURN: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pins follow the next state so they are registered with it.
    cs_n_d  = !(state_d inside {S_RD_ACC, S_WR_SET, S_WR_PUL, S_WR_HLD});
    oe_n_d  = (state_d != S_RD_ACC);
    we_n_d  = (state_d != S_WR_PUL);
    dq_oe_d = state_d inside {S_WR_SET, S_WR_PUL, S_WR_HLD};
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      addr_q      <= '0;
      dq_o_q      <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_n_q      <= cs_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      addr_q      <= addr_d;
      dq_o_q      <= dq_o_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef FLASH_RDY_POLL_EN
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      err_q     <= 1'b0;
      tmo_q     <= '0;
      ry_sync_q <= '0;
    end else begin
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      ry_sync_q <= ry_sync_d;
    end
  end

  assign rsp_err = err_q;
`else
  logic [TMO_W:0] unused_poll;
  assign unused_poll = {(TMO_W+1){flash_ry_by}};
  assign rsp_err     = 1'b0;
`endif

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign flash_addr  = addr_q;
  assign flash_dq_o  = dq_o_q;
  assign flash_dq_oe = dq_oe_q;
  assign flash_cs_n  = cs_n_q;
  assign flash_oe_n  = oe_n_q;
  assign flash_we_n  = we_n_q;

endmodule
